// File: rtl/rgb2yuv_core.sv
// rgb2yuv_core: converts RGB pixel pairs to a UYVY 4:2:2 byte stream and
// writes one byte per cycle into a byte-addressed frame buffer.
// Stage A holds one converted pair {U,Y0,V,Y1}. Stage B serializes it
// onto dout/addr_mem, one byte per clock. WIDTH*HEIGHT must not exceed 2^20.
module rgb2yuv_core #(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 480
) (
    input  logic        clk24,
    input  logic        rst_n,
    input  logic [47:0] din,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    output logic [7:0]  dout,
    output logic        we,
    output logic [19:0] addr_mem,
    output logic        frame_done
);

    localparam int unsigned FRAME_BYTES = WIDTH * HEIGHT;
    localparam int unsigned ADDR_W      = 20;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned CALC_W      = 20;
    localparam int unsigned IDX_W       = 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(3);

    localparam logic signed [CALC_W-1:0] C16  = CALC_W'(16);
    localparam logic signed [CALC_W-1:0] C18  = CALC_W'(18);
    localparam logic signed [CALC_W-1:0] C25  = CALC_W'(25);
    localparam logic signed [CALC_W-1:0] C38  = CALC_W'(38);
    localparam logic signed [CALC_W-1:0] C66  = CALC_W'(66);
    localparam logic signed [CALC_W-1:0] C74  = CALC_W'(74);
    localparam logic signed [CALC_W-1:0] C94  = CALC_W'(94);
    localparam logic signed [CALC_W-1:0] C112 = CALC_W'(112);
    localparam logic signed [CALC_W-1:0] C128 = CALC_W'(128);
    localparam logic signed [CALC_W-1:0] C129 = CALC_W'(129);
    localparam logic signed [CALC_W-1:0] C255 = CALC_W'(255);

    // Clamp a signed intermediate to the 0..255 byte range.
    function automatic logic [7:0] sat8(input logic signed [CALC_W-1:0] v);
        if (v[CALC_W-1]) begin
            return 8'd0;
        end else if (v > C255) begin
            return 8'd255;
        end else begin
            return 8'(v);
        end
    endfunction

    // Zero-extend an 8-bit channel into the signed working width.
    function automatic logic signed [CALC_W-1:0] ext(input logic [7:0] c);
        return $signed(CALC_W'(c));
    endfunction

    function automatic logic [7:0] calc_y(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        logic signed [CALC_W-1:0] acc;
        acc = C66 * ext(r) + C129 * ext(g) + C25 * ext(b) + C128;
        acc = (acc >>> 8) + C16;
        return sat8(acc);
    endfunction

    function automatic logic [7:0] calc_u(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        logic signed [CALC_W-1:0] acc;
        acc = C112 * ext(b) - C38 * ext(r) - C74 * ext(g) + C128;
        acc = (acc >>> 8) + C128;
        return sat8(acc);
    endfunction

    function automatic logic [7:0] calc_v(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        logic signed [CALC_W-1:0] acc;
        acc = C112 * ext(r) - C94 * ext(g) - C18 * ext(b) + C128;
        acc = (acc >>> 8) + C128;
        return sat8(acc);
    endfunction

    // Byte i of a {U,Y0,V,Y1} word, U first.
    function automatic logic [7:0] pick(input logic [WORD_W-1:0] w,
                                        input logic [IDX_W-1:0] i);
        logic [7:0] res;
        case (i)
            2'd0:    res = w[31:24];
            2'd1:    res = w[23:16];
            2'd2:    res = w[15:8];
            default: res = w[7:0];
        endcase
        return res;
    endfunction

    // Stage A: conversion register
    logic              a_full_q, a_full_d;
    logic              a_sof_q,  a_sof_d;
    logic [WORD_W-1:0] a_data_q, a_data_d;
    // Stage B: serializer
    logic              b_busy_q, b_busy_d;
    logic [IDX_W-1:0]  b_idx_q,  b_idx_d;
    logic [WORD_W-1:0] b_data_q, b_data_d;
    // Write port
    logic [7:0]        dout_q,   dout_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              fd_q,     fd_d;

    logic              accept;
    logic              xfer;
    logic              emit;
    logic [ADDR_W-1:0] addr_inc;
    logic [WORD_W-1:0] conv_word;

    // Handshake and A->B transfer; in_ready depends on state only.
    assign xfer     = a_full_q && (!b_busy_q || (b_idx_q == IDX_LAST));
    assign in_ready = !a_full_q || xfer;
    assign accept   = in_valid && in_ready;

    // Pair conversion: per-pixel luma, chroma from the truncated pair average.
    always_comb begin
        logic [7:0] r0, g0, b0, r1, g1, b1;
        logic [7:0] ra, ga, ba;
        g0 = din[7:0];
        b0 = din[15:8];
        r0 = din[23:16];
        g1 = din[31:24];
        b1 = din[39:32];
        r1 = din[47:40];
        ra = 8'((9'(r0) + 9'(r1)) >> 1);
        ga = 8'((9'(g0) + 9'(g1)) >> 1);
        ba = 8'((9'(b0) + 9'(b1)) >> 1);
        conv_word = {calc_u(ra, ga, ba), calc_y(r0, g0, b0),
                     calc_v(ra, ga, ba), calc_y(r1, g1, b1)};
    end

    // State register for both pipeline stages and the write port.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            a_full_q <= 1'b0;
            a_sof_q  <= 1'b0;
            a_data_q <= '0;
            b_busy_q <= 1'b0;
            b_idx_q  <= '0;
            b_data_q <= '0;
            dout_q   <= '0;
            addr_q   <= '0;
            fd_q     <= 1'b0;
        end else begin
            a_full_q <= a_full_d;
            a_sof_q  <= a_sof_d;
            a_data_q <= a_data_d;
            b_busy_q <= b_busy_d;
            b_idx_q  <= b_idx_d;
            b_data_q <= b_data_d;
            dout_q   <= dout_d;
            addr_q   <= addr_d;
            fd_q     <= fd_d;
        end
    end

    // Next state of stage A (load/unload) and stage B (byte index walk).
    always_comb begin
        a_full_d = a_full_q;
        a_sof_d  = a_sof_q;
        a_data_d = a_data_q;
        b_busy_d = b_busy_q;
        b_idx_d  = b_idx_q;
        b_data_d = b_data_q;

        if (xfer) begin
            a_full_d = 1'b0;
        end
        if (accept) begin
            a_full_d = 1'b1;
            a_sof_d  = in_sof;
            a_data_d = conv_word;
        end

        if (xfer) begin
            b_busy_d = 1'b1;
            b_idx_d  = '0;
            b_data_d = a_data_q;
        end else if (b_busy_q) begin
            if (b_idx_q == IDX_LAST) begin
                b_busy_d = 1'b0;
            end else begin
                b_idx_d = b_idx_q + IDX_W'(1);
            end
        end
    end

    // Write-port outputs: next byte, its address, and the end-of-frame flag.
    always_comb begin
        dout_d   = dout_q;
        addr_d   = addr_q;
        addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        emit     = xfer || (b_busy_q && (b_idx_q != IDX_LAST));

        if (xfer) begin
            // Idle B: addr_q already holds the next address. Busy B: step on.
            dout_d = a_data_q[31:24];
            if (a_sof_q) begin
                addr_d = '0;
            end else if (b_busy_q) begin
                addr_d = addr_inc;
            end
        end else if (b_busy_q) begin
            addr_d = addr_inc;
            if (b_idx_q != IDX_LAST) begin
                dout_d = pick(b_data_q, b_idx_q + IDX_W'(1));
            end
        end

        fd_d = emit && (addr_d == LAST_ADDR);
    end

    assign dout       = dout_q;
    assign we         = b_busy_q;
    assign addr_mem   = addr_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_rgb2yuv_core.sv
// Self-checking bench for rgb2yuv_core on a reduced 16x4-byte frame.
module tb_rgb2yuv_core;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 4;
    localparam int          FB = 64;

    logic        clk24 = 1'b0;
    logic        rst_n;
    logic [47:0] din;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [7:0]  dout;
    logic        we;
    logic [19:0] addr_mem;
    logic        frame_done;

    rgb2yuv_core #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk24      (clk24),
        .rst_n      (rst_n),
        .din        (din),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .dout       (dout),
        .we         (we),
        .addr_mem   (addr_mem),
        .frame_done (frame_done)
    );

    always #5 clk24 = ~clk24;

    typedef struct {
        logic [7:0]  d;
        logic [19:0] a;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   fd_count = 0;
    int   model_next = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fl8(input int x);
        return (x >= 0) ? x / 256 : -((-x + 255) / 256);
    endfunction

    function automatic int sat(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic logic [31:0] model(input logic [47:0] d);
        int g0, b0, r0, g1, b1, r1, ra, ga, ba, y0, y1, u, v;
        g0 = int'(d[7:0]);   b0 = int'(d[15:8]);  r0 = int'(d[23:16]);
        g1 = int'(d[31:24]); b1 = int'(d[39:32]); r1 = int'(d[47:40]);
        ra = (r0 + r1) / 2;  ga = (g0 + g1) / 2;  ba = (b0 + b1) / 2;
        y0 = sat(fl8(66 * r0 + 129 * g0 + 25 * b0 + 128) + 16);
        y1 = sat(fl8(66 * r1 + 129 * g1 + 25 * b1 + 128) + 16);
        u  = sat(fl8(-38 * ra - 74 * ga + 112 * ba + 128) + 128);
        v  = sat(fl8(112 * ra - 94 * ga - 18 * ba + 128) + 128);
        return {8'(u), 8'(y0), 8'(v), 8'(y1)};
    endfunction

    // Queue the four expected writes of one accepted pair.
    task automatic push_word(input logic [31:0] w, input logic sof);
        exp_t e;
        int   base;
        int   a;
        base = sof ? 0 : model_next;
        for (int i = 0; i < 4; i++) begin
            a    = (base + i) % FB;
            e.d  = w[31 - 8 * i -: 8];
            e.a  = 20'(a);
            e.fd = (a == FB - 1);
            sb.push_back(e);
        end
        model_next = (base + 4) % FB;
    endtask

    // Present one pair; returns at the negedge after it was accepted.
    task automatic send(input logic [47:0] d, input logic sof, input logic [31:0] w);
        int n;
        in_valid = 1'b1;
        din      = d;
        in_sof   = sof;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk24);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        push_word(w, sof);
        @(posedge clk24);
        @(negedge clk24);
        in_sof = 1'b0;
    endtask

    task automatic send_model(input logic [47:0] d, input logic sof);
        send(d, sof, model(d));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) @(negedge clk24);
    endtask

    // Monitor: every write is popped from the scoreboard and compared.
    always @(negedge clk24) begin
        if (rst_n) begin
            if (frame_done) fd_count++;
            if (we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(addr_mem), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("dout", 32'(dout), 32'(mon_e.d));
                    check("addr", 32'(addr_mem), 32'(mon_e.a));
                    check("frame_done", 32'(frame_done), 32'(mon_e.fd));
                end
            end else begin
                check("fd_while_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, rdy_low, rises, fd_before, n;
        logic prev;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        din      = '0;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr_mem), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk24);
        @(negedge clk24);
        rst_n = 1'b1;
        @(negedge clk24);

        // Single black pair: 128,16,128,16 at 0..3, we high for 4 cycles.
        send(48'h0, 1'b0, {8'd128, 8'd16, 8'd128, 8'd16});
        in_valid = 1'b0;
        check("t1_latency_we", 32'(we), 32'd0);
        wc = 0;
        rdy_low = 0;
        repeat (8) begin
            @(negedge clk24);
            if (we) wc++;
            if (!in_ready) rdy_low++;
        end
        check("t1_we_cycles", 32'(wc), 32'd4);
        check("t1_ready_low", 32'(rdy_low), 32'd0);
        idle(2);

        // Back-to-back white then red, restarted at address 0.
        send(48'hFFFF_FFFF_FFFF, 1'b1, {8'd128, 8'd235, 8'd128, 8'd235});
        send(48'hFF00_00FF_0000, 1'b0, {8'd90, 8'd82, 8'd240, 8'd82});
        in_valid = 1'b0;
        prev  = we;
        wc    = we ? 1 : 0;
        rises = 0;
        repeat (9) begin
            @(negedge clk24);
            if (we && !prev) rises++;
            if (we) wc++;
            prev = we;
        end
        check("t2_we_cycles", 32'(wc), 32'd8);
        check("t2_we_gap", 32'(rises), 32'd0);
        idle(2);

        // Full grey frame plus one more pair that must wrap to address 0.
        fd_before = fd_count;
        for (int i = 0; i < FB / 4 + 1; i++) begin
            send(48'h8080_8080_8080, (i == 0), {8'd128, 8'd126, 8'd128, 8'd126});
        end
        idle(8);
        check("t3_fd_pulses", 32'(fd_count - fd_before), 32'd1);

        // Random pairs, in_sof on pair 10 truncates the frame.
        fd_before = fd_count;
        for (int i = 0; i < 14; i++) begin
            send_model({16'($urandom), $urandom}, (i == 0 || i == 10));
        end
        idle(8);
        check("t4_fd_pulses", 32'(fd_count - fd_before), 32'd0);

        // Reset while byte index 2 is on the port.
        send_model({16'($urandom), $urandom}, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk24);
        rst_n = 1'b0;
        #1;
        check("t5_we", 32'(we), 32'd0);
        check("t5_addr", 32'(addr_mem), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        check("t5_dout", 32'(dout), 32'd0);
        sb.delete();
        model_next = 0;
        @(negedge clk24);
        rst_n = 1'b1;
        @(negedge clk24);

        // Averaging pair after reset lands at address 0.
        send(48'h0000_00FF_FF00, 1'b0, {8'd165, 8'd107, 8'd175, 8'd16});
        send_model({16'($urandom), $urandom}, 1'b0);
        idle(2);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk24);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
